// File: rtl/pcgen_pkg.sv
// Shared types for the fetch PC generator: 2-bit predictor counter encodings and BTB entry state.
package pcgen_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Width-independent part of a BTB entry; tag and target widths follow XLEN and live beside it.
  typedef struct packed {
    logic valid;
    ctr_e ctr;
  } btb_entry_t;

  function automatic ctr_e ctr_inc(input ctr_e c);
    case (c)
      SNT:     ctr_inc = WNT;
      WNT:     ctr_inc = WT;
      default: ctr_inc = ST;
    endcase
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    case (c)
      ST:      ctr_dec = WT;
      WT:      ctr_dec = WNT;
      default: ctr_dec = SNT;
    endcase
  endfunction

  function automatic logic ctr_taken(input ctr_e c);
    ctr_taken = (c == WT) || (c == ST);
  endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer with 2-bit saturating counters; lookup is combinational,
// training is written at the clock edge so a same-cycle lookup sees the old contents.
module btb_dm
  import pcgen_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-3:0] lk_pc_w,
  output logic            lk_taken_c,
  output logic [XLEN-3:0] lk_target_w_c,
  input  logic            upd_valid,
  input  logic [XLEN-3:0] upd_pc_w,
  input  logic [XLEN-3:0] upd_target_w,
  input  logic            upd_taken
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - 2 - IDX_W;

  btb_entry_t        meta_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q  [ENTRIES];
  logic [XLEN-3:0]   tgt_q  [ENTRIES];

  logic [IDX_W-1:0]  lk_idx, upd_idx;
  logic [TAG_W-1:0]  lk_tag, upd_tag;
  logic              lk_hit, upd_hit;

  always_comb begin
    lk_idx        = lk_pc_w[IDX_W-1:0];
    lk_tag        = lk_pc_w[XLEN-3:IDX_W];
    upd_idx       = upd_pc_w[IDX_W-1:0];
    upd_tag       = upd_pc_w[XLEN-3:IDX_W];
    lk_hit        = meta_q[lk_idx].valid && (tag_q[lk_idx] == lk_tag);
    upd_hit       = meta_q[upd_idx].valid && (tag_q[upd_idx] == upd_tag);
    lk_taken_c    = lk_hit && ctr_taken(meta_q[lk_idx].ctr);
    lk_target_w_c = tgt_q[lk_idx];
  end

  // Reset clears only valid/counter state; tag and target are qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        meta_q[i] <= '{valid: 1'b0, ctr: WNT};
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        meta_q[upd_idx].ctr <= upd_taken ? ctr_inc(meta_q[upd_idx].ctr)
                                         : ctr_dec(meta_q[upd_idx].ctr);
        if (upd_taken) tgt_q[upd_idx] <= upd_target_w;
      end else if (upd_taken) begin
        meta_q[upd_idx] <= '{valid: 1'b1, ctr: WT};
        tag_q[upd_idx]  <= upd_tag;
        tgt_q[upd_idx]  <= upd_target_w;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC register and next-PC select with BTB prediction.
// Optional trap redirect input enabled by defining PCGEN_TRAP_EN.
module fetch_pc_gen
  import pcgen_pkg::*;
#(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
  parameter int unsigned          BTB_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_f,
  input  logic            redirect_e,
  input  logic [XLEN-1:0] redirect_pc_e,
  input  logic            upd_valid_e,
  input  logic [XLEN-1:0] upd_pc_e,
  input  logic [XLEN-1:0] upd_target_e,
  input  logic            upd_taken_e,
`ifdef PCGEN_TRAP_EN
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
`endif
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] pc_plus4_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            btb_taken;
  logic [XLEN-3:0] btb_target_w;

  // Low address bits are forced to zero on use, so they are intentionally not consumed.
  logic unused_low_bits;
`ifdef PCGEN_TRAP_EN
  assign unused_low_bits = ^{redirect_pc_e[1:0], upd_pc_e[1:0], upd_target_e[1:0], trap_vec[1:0]};
`else
  assign unused_low_bits = ^{redirect_pc_e[1:0], upd_pc_e[1:0], upd_target_e[1:0]};
`endif

  btb_dm #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lk_pc_w       (pc_q[XLEN-1:2]),
    .lk_taken_c    (btb_taken),
    .lk_target_w_c (btb_target_w),
    .upd_valid     (upd_valid_e),
    .upd_pc_w      (upd_pc_e[XLEN-1:2]),
    .upd_target_w  (upd_target_e[XLEN-1:2]),
    .upd_taken     (upd_taken_e)
  );

  always_comb begin
    pc_f          = pc_q;
    pc_plus4_f    = pc_q + XLEN'(4);
    pred_taken_f  = btb_taken;
    pred_target_f = btb_taken ? {btb_target_w, 2'b00} : pc_plus4_f;
  end

  // Assignment order gives priority: later statements win.
  always_comb begin
    pc_d = pred_target_f;
    if (stall_f)    pc_d = pc_q;
    if (redirect_e) pc_d = {redirect_pc_e[XLEN-1:2], 2'b00};
`ifdef PCGEN_TRAP_EN
    if (trap_valid) pc_d = {trap_vec[XLEN-1:2], 2'b00};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_VECTOR;
    else     pc_q <= pc_d;
  end

endmodule
